adc_seq_avg: RTL

- Parametrised successor to the team's fixed 3-channel serial ADC reader for the ADC128S022-style 8-channel, 12-bit SPI converter.
- Walks a run-time channel-enable mask round-robin and drives CS_n, DIN and the 16-clock frame.
- Averages 2^AVG_LOG2 conversions per channel and publishes one result register per channel with a one-cycle valid strobe.
- Sits between the on-board ADC pins and the sensor and line-follow logic.

---
 rtl/adc_seq_avg.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/adc_seq_avg.sv
// Round-robin sequencer and per-channel averager for an ADC128S022-style 8-channel, 12-bit SPI ADC.
// Frame data is pipelined one frame behind the address that selected it.
module adc_seq_avg #(
    parameter int NUM_CH   = 3,
    parameter int CH_BASE  = 1,
    parameter int AVG_LOG2 = 0
) (
    input  logic                   sclk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [NUM_CH-1:0]      ch_en,
    input  logic                   dout,
    output logic                   din,
    output logic                   CS_n,
    output logic [NUM_CH*12-1:0]   adc_data,
    output logic [NUM_CH-1:0]      data_valid
);

    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int N_W   = AVG_LOG2 + 1;
    localparam logic [N_W-1:0] N_LAST = N_W'((1 << AVG_LOG2) - 1);

    typedef enum logic {IDLE = 1'b0, FRAME = 1'b1} state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [2:0]        cur_addr_q, cur_addr_d;
    logic [2:0]        prev_addr_q, prev_addr_d;
    logic              prime_q, prime_d;
    logic [10:0]       shreg_q, shreg_d;
    logic [ACC_W-1:0]  acc_q [NUM_CH];
    logic [ACC_W-1:0]  acc_d [NUM_CH];
    logic [N_W-1:0]    n_q [NUM_CH];
    logic [N_W-1:0]    n_d [NUM_CH];
    logic [11:0]       data_q [NUM_CH];
    logic [11:0]       data_d [NUM_CH];
    logic [NUM_CH-1:0] valid_q, valid_d;
    logic              din_q;

    logic [11:0]       sample;
    logic [ACC_W-1:0]  sum;
    logic [2:0]        addr_phys;
    logic              any_en;
    logic              frame_end;
    logic              commit;

    function automatic logic [2:0] next_ch(input logic [2:0] cur, input logic [NUM_CH-1:0] mask);
        logic [2:0] nxt;
        logic       found;
        int         idx;
        nxt   = cur;
        found = 1'b0;
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = (int'(cur) + i) % NUM_CH;
            if (!found && mask[idx]) begin
                nxt   = 3'(idx);
                found = 1'b1;
            end
        end
        return nxt;
    endfunction

    assign sample    = {shreg_q, dout};
    assign addr_phys = cur_addr_q + 3'(CH_BASE);
    assign any_en    = |ch_en;
    assign frame_end = (state_q == FRAME) && (cnt_q == 4'd15);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cur_addr_d  = cur_addr_q;
        prev_addr_d = prev_addr_q;
        prime_d     = prime_q;
        shreg_d     = shreg_q;
        valid_d     = '0;
        sum         = '0;
        commit      = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            acc_d[k]  = acc_q[k];
            n_d[k]    = n_q[k];
            data_d[k] = data_q[k];
        end

        case (state_q)
            IDLE: begin
                cnt_d = 4'd0;
                if (en && any_en) begin
                    state_d    = FRAME;
                    prime_d    = 1'b1;
                    cur_addr_d = next_ch(cur_addr_q, ch_en);
                end
            end
            FRAME: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q >= 4'd4) begin
                    shreg_d = sample[10:0];
                end
                if (cnt_q == 4'd15) begin
                    cnt_d = 4'd0;
                    if (en && any_en) begin
                        prev_addr_d = cur_addr_q;
                        cur_addr_d  = next_ch(cur_addr_q, ch_en);
                        prime_d     = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A disabled channel loses its partial average; a commit to it is dropped.
        for (int k = 0; k < NUM_CH; k++) begin
            commit = frame_end && !prime_q && (prev_addr_q == 3'(k)) && ch_en[k];
            if (!ch_en[k]) begin
                acc_d[k] = '0;
                n_d[k]   = '0;
            end else if (commit) begin
                sum = acc_q[k] + ACC_W'(sample);
                if (n_q[k] == N_LAST) begin
                    data_d[k]  = 12'(sum >> AVG_LOG2);
                    valid_d[k] = 1'b1;
                    acc_d[k]   = '0;
                    n_d[k]     = '0;
                end else begin
                    acc_d[k] = sum;
                    n_d[k]   = n_q[k] + N_W'(1);
                end
            end
        end
    end

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            cur_addr_q  <= 3'(NUM_CH - 1);
            prev_addr_q <= 3'd0;
            prime_q     <= 1'b1;
            shreg_q     <= '0;
            valid_q     <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                acc_q[k]  <= '0;
                n_q[k]    <= '0;
                data_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_addr_q  <= cur_addr_d;
            prev_addr_q <= prev_addr_d;
            prime_q     <= prime_d;
            shreg_q     <= shreg_d;
            valid_q     <= valid_d;
            for (int k = 0; k < NUM_CH; k++) begin
                acc_q[k]  <= acc_d[k];
                n_q[k]    <= n_d[k];
                data_q[k] <= data_d[k];
            end
        end
    end

    // Address bits launch on the falling edge so the ADC sees them stable at the next rise.
    always_ff @(negedge sclk or posedge rst) begin
        if (rst) begin
            din_q <= 1'b0;
        end else if (state_q == FRAME) begin
            case (cnt_q)
                4'd2:    din_q <= addr_phys[2];
                4'd3:    din_q <= addr_phys[1];
                4'd4:    din_q <= addr_phys[0];
                default: din_q <= 1'b0;
            endcase
        end else begin
            din_q <= 1'b0;
        end
    end

    always_comb begin
        adc_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            adc_data[12*k +: 12] = data_q[k];
        end
    end

    assign CS_n       = (state_q == IDLE);
    assign din        = din_q;
    assign data_valid = valid_q;

endmodule
